// File: rtl/mux8_rr_sequencer_pkg.sv
// Shared constants for the 8-channel round-robin mux sequencer.
//   NUM_CH / SEL_W : channel count and select width
//   ST_*           : FSM state encodings (2'd3 is unused and recovers to ST_IDLE)
package mux8_rr_sequencer_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEL  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

endpackage

// File: rtl/mux8_rr_sequencer_if.sv
// Output stream interface of the sequencer.
//   m_valid : word valid (driven by master)
//   m_ready : consumer ready (driven by slave)
//   m_data  : captured word
//   m_ch    : channel index of m_data
// Handshake: a word transfers on a rising clk edge where m_valid && m_ready.
// Once m_valid is high, the master holds m_valid, m_data and m_ch stable
// until that transfer; m_valid never depends combinationally on m_ready.
interface mux8_rr_sequencer_if
  import mux8_rr_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 16
);

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [SEL_W-1:0]      m_ch;

  modport master (
    output m_valid,
    output m_data,
    output m_ch,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_ch,
    output m_ready
  );

endinterface

// File: rtl/mux8_rr_sequencer_rr_pick8.sv
// Combinational round-robin picker for eight requesters.
//   req    : request vector
//   last   : last granted channel
//   found  : at least one request set
//   winner : first set request searching last+1, last+2, ... (mod 8)
module rr_pick8 (
  input  logic [7:0] req,
  input  logic [2:0] last,
  output logic       found,
  output logic [2:0] winner
);

  logic [2:0] idx;

  always_comb begin
    found  = 1'b0;
    winner = 3'd0;
    idx    = 3'd0;
    // k = 8 wraps back to last itself, so a lone request from the last
    // granted channel is still served.
    for (int k = 1; k <= 8; k++) begin
      idx = last + 3'(k);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/mux8to1.sv
// Combinational 8:1 word mux.
//   in_data : eight packed words, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   sel     : word index
//   out     : selected word
module mux8to1 #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [8*DATA_WIDTH-1:0] in_data,
  input  logic [2:0]              sel,
  output logic [DATA_WIDTH-1:0]   out
);

  always_comb begin
    out = in_data[sel*DATA_WIDTH +: DATA_WIDTH];
  end

endmodule

// File: rtl/mux8_rr_sequencer.sv
// Round-robin sequencer sharing one 8:1 mux between eight producer channels.
//   clk, rst  : clock, asynchronous active-high reset
//   enable    : permits new grants (a transaction in flight always completes)
//   req       : per-channel level requests
//   in_data   : channel words, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ack       : one-hot pulse in the SEL cycle; the word is captured that cycle
//   sel       : registered mux select
//   m_if      : output stream (valid/ready, data, channel)
//   busy      : FSM not in IDLE
//   dbg_state : current FSM state
module mux8_rr_sequencer
  import mux8_rr_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [NUM_CH-1:0]            req,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]            ack,
  output logic [SEL_W-1:0]             sel,
  mux8_rr_sequencer_if.master          m_if,
  output logic                         busy,
  output logic [1:0]                   dbg_state
);

  logic [1:0]            state_q,   state_d;
  logic [SEL_W-1:0]      sel_q,     sel_d;
  logic [SEL_W-1:0]      last_q,    last_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q,  m_data_d;
  logic [SEL_W-1:0]      m_ch_q,    m_ch_d;

  logic                  pick_found;
  logic [SEL_W-1:0]      pick_winner;
  logic [DATA_WIDTH-1:0] mux_out;
  logic                  arb_ok;

  rr_pick8 u_pick (
    .req    (req),
    .last   (last_q),
    .found  (pick_found),
    .winner (pick_winner)
  );

  mux8to1 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mux (
    .in_data (in_data),
    .sel     (sel_q),
    .out     (mux_out)
  );

  assign arb_ok = enable && pick_found;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ch_d    = m_ch_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_ok) begin
          state_d = ST_SEL;
          sel_d   = pick_winner;
        end
      end
      ST_SEL: begin
        // sel has been stable for a full cycle, so the mux output is settled.
        state_d   = ST_OUT;
        m_data_d  = mux_out;
        m_ch_d    = sel_q;
        m_valid_d = 1'b1;
        last_d    = sel_q;
      end
      ST_OUT: begin
        if (m_if.m_ready) begin
          m_valid_d = 1'b0;
          if (arb_ok) begin
            state_d = ST_SEL;
            sel_d   = pick_winner;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        m_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      last_q    <= 3'd7;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_ch_q    <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_ch_q    <= m_ch_d;
    end
  end

  // ack decodes straight from state so an async reset clears it at once.
  assign ack          = (state_q == ST_SEL) ? (8'd1 << sel_q) : 8'd0;
  assign sel          = sel_q;
  assign busy         = (state_q != ST_IDLE);
  assign dbg_state    = state_q;
  assign m_if.m_valid = m_valid_q;
  assign m_if.m_data  = m_data_q;
  assign m_if.m_ch    = m_ch_q;

endmodule

// File: doc/mux8_rr_sequencer.md
# mux8_rr_sequencer

Round-robin scheduler that shares one 8:1 datapath mux between eight producer channels. It arbitrates pending channel requests, drives the mux select, and captures the selected word into a registered output stage. The stage presents the word to a downstream consumer with a valid/ready handshake. The block sits in the AXI control wrapper, between per-channel result sources and the AXI-facing stream/register logic.

## Interface
- DATA_WIDTH, 16, width of each channel word and of the output word
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-high reset
- enable  input  1  permits new grants; does not abort a transaction in progress
- req  input  8  per-channel request, level; bit i = channel i has a word ready
- in_data  input  8*DATA_WIDTH  channel words, channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- ack  output  8  one-hot, one-cycle pulse; the granted channel's word is captured this cycle
- sel  output  3  registered mux select, currently granted channel
- m_valid  output  1  output word valid
- m_ready  input  1  consumer accepts the word when m_valid && m_ready
- m_data  output  DATA_WIDTH  captured word
- m_ch  output  3  channel index of m_data
- busy  output  1  high in every state except IDLE

## Operation
- FSM states:
  - IDLE: no grant outstanding.
  - SEL: sel is driven, mux output settling, ack is pulsed.
  - OUT: word held, m_valid=1.
- IDLE → SEL: when enable && |req.
  - winner = first set req bit searching last+1, last+2, … wrapping mod 8, where last is the last granted channel.
  - sel <= winner.
- SEL → OUT, always after exactly one cycle.
  - ack = one-hot(sel), combinational from state==SEL.
  - m_data <= mux(in_data, sel); m_ch <= sel; m_valid <= 1; last <= sel.
- OUT, m_ready=0: hold m_valid, m_data and m_ch stable; no ack; no new grant.
- OUT, m_ready=1, enable && |req: go directly to SEL with a new round-robin winner; m_valid <= 0.
- OUT, m_ready=1, otherwise: go to IDLE; m_valid <= 0.
- Producer rules:
  - Hold in_data stable while req is high, through the ack cycle.
  - Deassert req on the edge after ack unless another word is ready.
  - A req still high in the cycle after ack is a new request.
- Round-robin wrap uses natural 3-bit arithmetic (7+1 → 0).
- last resets to 7, so channel 0 has first priority after reset.
- enable low: a transaction already in SEL/OUT completes normally, then the FSM stays in IDLE. Requests are not lost; they stay pending on req.
- req bits that rise or fall while the FSM is in SEL or OUT are ignored until the next arbitration point (IDLE, or OUT with m_ready=1).

## Timing
- Reset values: state=IDLE, sel=0, last=7, ack=0, m_valid=0, m_data=0, m_ch=0, busy=0. These apply immediately on rst assertion, including mid-transaction. Any word in flight is discarded and no ack is repeated.
- Latency, req to ack: req seen in IDLE at cycle N → sel valid and ack pulse in cycle N+1 → m_valid in cycle N+2.
- Throughput: with m_ready held high and requests pending, one word every 2 cycles (SEL, OUT, SEL, OUT, …).
- The mux is purely combinational. Its output is sampled only at the SEL→OUT edge, one full cycle after sel is registered.
- Simultaneous events:
  - m_ready accept and a new request in the same OUT cycle: the next grant starts on the same edge.
  - Requests from every channel: strict rotation with no starvation; worst-case wait is 7 grants.

## Structure
- Shared package holds:
  - NUM_CH=8 and SEL_W=3.
  - State encodings ST_IDLE=2'd0, ST_SEL=2'd1, ST_OUT=2'd2.
  - Unused encoding 2'd3 recovers to ST_IDLE.
- The datapath mux is an instance of the team's existing 8:1 mux module, `mux8to1`, with DATA_WIDTH passed through.
- One natural new sub-module: `rr_pick8`, combinational. Inputs req[7:0] and last[2:0]; outputs found and winner[2:0].

## Test plan
- Reset: assert rst mid-run → all outputs at reset values within the same cycle; after release, req=8'hFF → first grant is channel 0.
- Single request: req=8'b0000_1000, channel 3 data 16'h1234, m_ready=1 → cycle+1: sel=3, ack=8'b0000_1000; cycle+2: m_valid=1, m_data=16'h1234, m_ch=3; then IDLE.
- Full contention: all req held high, m_ready=1 → grants in order 0,1,…,7,0; m_valid every other cycle; each ack exactly once per rotation.
- Backpressure: m_ready=0 for 5 cycles during OUT, with other reqs pending → m_data/m_ch stable, no ack; on m_ready=1, the next channel is granted on the same edge.
- Enable drop: enable falls during SEL → that word still appears on m_data and is accepted; with req=8'hFF held, no further ack until enable returns.
- Async reset in SEL: rst pulse while ack is active → ack and m_valid go to 0 immediately; no m_valid appears for that channel.
